// File: rtl/sector_hexdump_if.sv
// ---------------------------------------------------------------------------
// sector_hexdump_if
//   Bundles the sector-capture write strobe, the character request/grant
//   handshake and the status flags of sector_hexdump.
//
//   Capture side : inreq (strobe), inaddr[8:0] (byte index), inbyte[7:0]
//   Output side  : oreq (character valid), ogrant (accepted), odata[7:0]
//   Status       : busy (dump running), done (end pulse), overrun (sticky)
//
//   slave  : view of the formatter (consumes capture writes and grants)
//   master : view of the environment (drives writes and grants)
// ---------------------------------------------------------------------------
interface sector_hexdump_if;
  logic       inreq;
  logic [8:0] inaddr;
  logic [7:0] inbyte;
  logic       oreq;
  logic       ogrant;
  logic [7:0] odata;
  logic       busy;
  logic       done;
  logic       overrun;

  modport slave (
    input  inreq, inaddr, inbyte, ogrant,
    output oreq, odata, busy, done, overrun
  );

  modport master (
    output inreq, inaddr, inbyte, ogrant,
    input  oreq, odata, busy, done, overrun
  );
endinterface

// File: rtl/sector_hexdump.sv
// ---------------------------------------------------------------------------
// sector_hexdump
//   Captures one 512-byte sector written by address and, once byte 511 is
//   written, emits it as ASCII hex text: "HL " per byte and CR LF after every
//   LINE_BYTES bytes. Characters leave through a request/grant handshake so
//   the downstream UART FIFO can stall the dump.
//
//   Parameters
//     LINE_BYTES : bytes per text line (power of two, 1..512)
//     UPPERCASE  : 1 -> 'A'..'F', 0 -> 'a'..'f'
//
//   Ports
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     bus    : sector_hexdump_if.slave (capture writes, character
//              handshake, busy/done/overrun status)
// ---------------------------------------------------------------------------
module sector_hexdump #(
  parameter int unsigned LINE_BYTES = 16,
  parameter bit          UPPERCASE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sector_hexdump_if.slave         bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_SEP   = 3'd4,
    ST_CR    = 3'd5,
    ST_LF    = 3'd6
  } state_e;

  // Low idx bits that select the position within a line. For LINE_BYTES=1
  // the mask is zero, so every byte ends a line.
  localparam logic [8:0] LINE_MASK = 9'(LINE_BYTES - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // One nibble to its ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] alpha_base;
    alpha_base = UPPERCASE ? 8'h41 : 8'h61;
    if (nib < 4'd10) begin
      hex_char = 8'h30 + {4'h0, nib};
    end else begin
      hex_char = alpha_base + {4'h0, nib} - 8'd10;
    end
  endfunction

  state_e     state_q,   state_d;
  logic [8:0] idx_q,     idx_d;
  logic       oreq_q,    oreq_d;
  logic [7:0] odata_q,   odata_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       overrun_q, overrun_d;

  logic [7:0] mem_q [512];
  logic [7:0] rd_data_q;
  logic       wr_en_s;
  logic [8:0] rd_addr_s;
  logic       line_end_s;

  // The read is launched with the next index, so rd_data_q already holds
  // buffer[idx] during FETCH and the first digit can be registered out of
  // FETCH. The buffer is only written in IDLE, so rd_data_q stays valid for
  // the HI and LO characters of the same byte.
  assign rd_addr_s  = idx_d;
  assign line_end_s = ((idx_q & LINE_MASK) == LINE_MASK);

  // Sector buffer: write port plus registered read port, no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[bus.inaddr] <= bus.inbyte;
    end
    rd_data_q <= mem_q[rd_addr_s];
  end

  // Next-state, next-output and write-enable decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    oreq_d    = oreq_q;
    odata_d   = odata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (bus.inreq & busy_q);
    wr_en_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        oreq_d = 1'b0;
        busy_d = 1'b0;
        if (bus.inreq) begin
          wr_en_s = 1'b1;
          if (bus.inaddr == 9'd511) begin
            state_d = ST_FETCH;
            idx_d   = 9'd0;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end

      ST_FETCH: begin
        state_d = ST_HI;
        oreq_d  = 1'b1;
        odata_d = hex_char(rd_data_q[7:4]);
      end

      ST_HI: begin
        if (bus.ogrant) begin
          state_d = ST_LO;
          odata_d = hex_char(rd_data_q[3:0]);
        end else begin
          state_d = ST_HI;
        end
      end

      ST_LO: begin
        if (bus.ogrant) begin
          state_d = ST_SEP;
          odata_d = CH_SPACE;
        end else begin
          state_d = ST_LO;
        end
      end

      ST_SEP: begin
        if (bus.ogrant) begin
          if (line_end_s) begin
            state_d = ST_CR;
            odata_d = CH_CR;
          end else begin
            state_d = ST_FETCH;
            idx_d   = idx_q + 9'd1;
            oreq_d  = 1'b0;
          end
        end else begin
          state_d = ST_SEP;
        end
      end

      ST_CR: begin
        if (bus.ogrant) begin
          state_d = ST_LF;
          odata_d = CH_LF;
        end else begin
          state_d = ST_CR;
        end
      end

      ST_LF: begin
        if (bus.ogrant) begin
          oreq_d = 1'b0;
          // End test before increment: idx never wraps inside a dump.
          if (idx_q == 9'd511) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            idx_d   = idx_q + 9'd1;
          end
        end else begin
          state_d = ST_LF;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 9'd0;
        oreq_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Formatter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 9'd0;
      oreq_q    <= 1'b0;
      odata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      oreq_q    <= oreq_d;
      odata_q   <= odata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.oreq    = oreq_q;
  assign bus.odata   = odata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sector_hexdump.sv
// ---------------------------------------------------------------------------
// tb_sector_hexdump
//   Two formatters: dut_a (16 bytes/line, uppercase) and dut_b (32 bytes/line,
//   lowercase). A scenario table drives captures and dumps; every emitted
//   character is compared with text derived from the bench's copy of the
//   sector. Reset-abort and descending-write cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_sector_hexdump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       inreq_s;
  logic [8:0] inaddr_s;
  logic [7:0] inbyte_s;
  logic       ogrant_s;

  sector_hexdump_if a_if ();
  sector_hexdump_if b_if ();

  assign a_if.inreq  = inreq_s & ~sel;
  assign a_if.inaddr = inaddr_s;
  assign a_if.inbyte = inbyte_s;
  assign a_if.ogrant = ogrant_s;
  assign b_if.inreq  = inreq_s & sel;
  assign b_if.inaddr = inaddr_s;
  assign b_if.inbyte = inbyte_s;
  assign b_if.ogrant = ogrant_s;

  wire       oreq_m    = sel ? b_if.oreq    : a_if.oreq;
  wire [7:0] odata_m   = sel ? b_if.odata   : a_if.odata;
  wire       busy_m    = sel ? b_if.busy    : a_if.busy;
  wire       done_m    = sel ? b_if.done    : a_if.done;
  wire       overrun_m = sel ? b_if.overrun : a_if.overrun;

  sector_hexdump #(.LINE_BYTES(16), .UPPERCASE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );

  sector_hexdump #(.LINE_BYTES(32), .UPPERCASE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_a [512];
  logic [7:0] mem_b [512];

  // dump results
  int         r_nchar, r_bad, r_first_bad, r_stall;
  int         r_done_k, r_last_k, r_first_oreq_k;
  logic       r_busy1, r_busy_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_val(input int p, input int i);
    int v;
    case (p)
      0:       v = i;
      1:       v = 8'hAB;
      default: v = i * 7 + 3;
    endcase
    return 8'(v);
  endfunction

  // Expected character number k of the dump text of the selected DUT.
  function automatic logic [7:0] exp_char(input logic s, input int k);
    int    lb, per_line, line, pos, bi;
    logic [7:0] b;
    string hx;
    lb       = s ? 32 : 16;
    hx       = s ? "0123456789abcdef" : "0123456789ABCDEF";
    per_line = lb * 3 + 2;
    line     = k / per_line;
    pos      = k % per_line;
    if (pos == lb * 3)     return 8'h0D;
    if (pos == lb * 3 + 1) return 8'h0A;
    bi = line * lb + pos / 3;
    b  = s ? mem_b[bi] : mem_a[bi];
    case (pos % 3)
      0:       return hx[b[7:4]];
      1:       return hx[b[3:0]];
      default: return 8'h20;
    endcase
  endfunction

  task automatic model_write(input logic [8:0] a, input logic [7:0] d);
    if (sel) mem_b[a] = d;
    else     mem_a[a] = d;
  endtask

  // Writes bytes 0..510 of pattern p back to back (pattern 2 = leave as is).
  task automatic fill(input int p);
    if (p != 2) begin
      for (int i = 0; i < 511; i++) begin
        @(negedge clk);
        inreq_s  = 1'b1;
        inaddr_s = 9'(i);
        inbyte_s = pat_val(p, i);
        model_write(9'(i), pat_val(p, i));
      end
      @(negedge clk);
      inreq_s = 1'b0;
    end
  endtask

  // Triggers a dump by writing addr 511, then collects characters.
  // mode: 0 plain, 1 poke addr 5 at k=100, 2 descending writes 510..0,
  //       3 write addr 3 in the done cycle. stop_at>0 returns after that
  //       many transfers without waiting for done.
  // k counts negedges after the trigger edge: k = cycle N+k.
  task automatic run_dump(input logic [7:0] trig, input int pct,
                          input int mode, input int stop_at);
    int         k;
    logic       hold, g, fin;
    logic [7:0] hold_data;
    k = 0; hold = 1'b0; fin = 1'b0; hold_data = 8'h00;
    r_nchar = 0; r_bad = 0; r_first_bad = -1; r_stall = 0;
    r_done_k = 0; r_last_k = 0; r_first_oreq_k = 0;
    r_busy1 = 1'b0; r_busy_done = 1'b1;
    @(negedge clk);
    inreq_s  = 1'b1;
    inaddr_s = 9'd511;
    inbyte_s = trig;
    model_write(9'd511, trig);
    while (!fin && k < 20000) begin
      @(negedge clk);
      k++;
      inreq_s = 1'b0;
      if (mode == 2 && k <= 511) begin
        inreq_s  = 1'b1;
        inaddr_s = 9'(511 - k);
        inbyte_s = 8'hC0;
      end
      if (mode == 1 && k == 100) begin
        inreq_s  = 1'b1;
        inaddr_s = 9'd5;
        inbyte_s = 8'h77;
      end
      if (k == 1) r_busy1 = busy_m;
      if (hold && odata_m != hold_data) r_stall++;
      if (done_m) begin
        fin         = 1'b1;
        r_done_k    = k;
        r_busy_done = busy_m;
        ogrant_s    = 1'b0;
        if (mode == 3) begin
          inreq_s  = 1'b1;
          inaddr_s = 9'd3;
          inbyte_s = 8'h5A;
          model_write(9'd3, 8'h5A);
        end
      end else begin
        g        = ($urandom_range(99, 0) < pct);
        ogrant_s = g;
        if (oreq_m && r_first_oreq_k == 0) r_first_oreq_k = k;
        if (oreq_m && g) begin
          if (odata_m != exp_char(sel, r_nchar)) begin
            if (r_bad == 0) r_first_bad = r_nchar;
            r_bad++;
          end
          r_nchar++;
          r_last_k = k;
          if (stop_at != 0 && r_nchar == stop_at) fin = 1'b1;
        end
        hold      = oreq_m && !g;
        hold_data = odata_m;
      end
    end
    if (stop_at == 0) begin
      @(negedge clk);
      inreq_s  = 1'b0;
      ogrant_s = 1'b0;
    end
  endtask

  typedef struct {
    logic       s;
    int         pattern;
    logic [7:0] trig;
    int         pct;
    int         mode;
    int         exp_nchar;
    int         exp_done_k;   // 0: grant-dependent, only presence checked
    int         exp_over;
  } vec_t;

  vec_t vecs [5];

  int   pulses, oreqs;

  initial begin
    // in-order 0..511, full rate, write accepted in the done cycle
    vecs[0] = '{1'b0, 0, 8'hFF, 100, 3, 1600, 2113, 0};
    // 0xAB everywhere, 32 bytes/line lowercase
    vecs[1] = '{1'b1, 1, 8'hAB, 100, 0, 1568, 2081, 0};
    // same sector (byte 3 now 0x5A), ~30% grant
    vecs[2] = '{1'b0, 2, 8'hFF,  30, 0, 1600, 0,    0};
    // poke addr 5 while busy -> overrun, buffer untouched
    vecs[3] = '{1'b0, 2, 8'hFF, 100, 1, 1600, 2113, 1};
    // re-trigger: byte 5 still original, overrun still set
    vecs[4] = '{1'b0, 2, 8'hFF, 100, 0, 1600, 2113, 1};

    sel = 1'b0; inreq_s = 1'b0; inaddr_s = 9'd0; inbyte_s = 8'h00;
    ogrant_s = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oreq",    int'(a_if.oreq),    0);
    check("rst_odata",   int'(a_if.odata),   0);
    check("rst_busy",    int'(a_if.busy),    0);
    check("rst_done",    int'(a_if.done),    0);
    check("rst_overrun", int'(a_if.overrun), 0);
    check("rst_b_oreq",  int'(b_if.oreq),    0);
    rst_n = 1'b1;
    // ogrant with oreq low must not start anything
    ogrant_s = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_grant_oreq", int'(a_if.oreq), 0);
    ogrant_s = 1'b0;

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      sel = vecs[v].s;
      fill(vecs[v].pattern);
      run_dump(vecs[v].trig, vecs[v].pct, vecs[v].mode, 0);
      check($sformatf("v%0d_stream_bad(first=%0d)", v, r_first_bad), r_bad, 0);
      check($sformatf("v%0d_nchar", v), r_nchar, vecs[v].exp_nchar);
      check($sformatf("v%0d_busy_at_n1", v), int'(r_busy1), 1);
      check($sformatf("v%0d_first_oreq_k", v), r_first_oreq_k, 2);
      check($sformatf("v%0d_stall_changes", v), r_stall, 0);
      check($sformatf("v%0d_busy_at_done", v), int'(r_busy_done), 0);
      check($sformatf("v%0d_overrun", v), int'(overrun_m), vecs[v].exp_over);
      if (vecs[v].exp_done_k != 0) begin
        check($sformatf("v%0d_done_k", v), r_done_k, vecs[v].exp_done_k);
        check($sformatf("v%0d_last_lf_k", v), r_last_k, vecs[v].exp_done_k - 1);
      end else begin
        check($sformatf("v%0d_done_seen", v), int'(r_done_k > 0), 1);
      end
    end

    // Reset in the middle of a dump: outputs drop at once, no done.
    sel = 1'b0;
    fill(3);
    run_dump(pat_val(3, 511), 100, 0, 700);
    check("abort_chars_before", r_bad, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_oreq",    int'(a_if.oreq),    0);
    check("abort_busy",    int'(a_if.busy),    0);
    check("abort_overrun", int'(a_if.overrun), 0);
    ogrant_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; oreqs = 0;
    ogrant_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_if.done) pulses++;
      if (a_if.oreq) oreqs++;
    end
    ogrant_s = 1'b0;
    check("abort_no_done", pulses, 0);
    check("abort_no_oreq", oreqs,  0);

    // Fresh capture after the abort gives a complete dump.
    fill(3);
    run_dump(pat_val(3, 511), 100, 0, 0);
    check("fresh_stream_bad", r_bad, 0);
    check("fresh_nchar",      r_nchar, 1600);
    check("fresh_done_k",     r_done_k, 2113);
    check("fresh_overrun",    int'(a_if.overrun), 0);

    // Descending writes, 511 first: dump starts at once, rest dropped.
    run_dump(8'h11, 100, 2, 0);
    check("desc_stream_bad", r_bad, 0);
    check("desc_nchar",      r_nchar, 1600);
    check("desc_done_k",     r_done_k, 2113);
    check("desc_overrun",    int'(a_if.overrun), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sector_hexdump.md
# sector_hexdump

Formatting stage between the SD sector reader's byte stream and the UART transmitter. It captures one 512-byte sector written by address, then emits it as ASCII hex text:

- two hex digits plus a space per byte;
- CR LF after every LINE_BYTES bytes.

Output uses a request/grant handshake, so the downstream UART FIFO can apply backpressure, which the raw sector stream cannot.

## Interface
- LINE_BYTES, 16: bytes per text line; power of two, 1..512.
- UPPERCASE, 1: 1 selects 'A'-'F' (0x41..0x46); 0 selects 'a'-'f' (0x61..0x66).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- inreq  in  1  one-cycle strobe: inbyte is sector byte number inaddr.
- inaddr  in  9  byte index within sector, 0..511.
- inbyte  in  8  sector data byte.
- oreq  out  1  odata valid, requesting transfer.
- ogrant  in  1  downstream accepts odata this cycle.
- odata  out  8  ASCII character.
- busy  out  1  dump in progress; input writes ignored.
- done  out  1  one-cycle pulse after the final LF is transferred.
- overrun  out  1  sticky: an inreq arrived while busy.

## Operation
- Storage: 512x8 buffer with synchronous read (BRAM-inferable).
  - While busy=0, every inreq writes inbyte to buffer[inaddr].
  - Out-of-order addresses are allowed.
- Trigger: an accepted write with inaddr==511 starts a dump on the next cycle.
  - Bytes 0..510 not written since reset hold stale or undefined data; they are dumped as-is.
- While busy=1:
  - inreq is ignored and the buffer is not written.
  - overrun is set and held until reset.
- State machine:
  - IDLE: capture writes; on write of addr 511 go to FETCH and set byte counter idx=0.
  - FETCH: issue read of buffer[idx]; go to HI.
  - HI: odata = hex(byte[7:4]); on transfer go to LO.
  - LO: odata = hex(byte[3:0]); on transfer go to SEP.
  - SEP: odata = 0x20; on transfer:
    - if idx[log2(LINE_BYTES)-1:0] == LINE_BYTES-1, go to CR;
    - else idx++ and go to FETCH.
  - CR: odata = 0x0D; on transfer go to LF.
  - LF: odata = 0x0A; on transfer:
    - if idx==511, go to IDLE and pulse done;
    - else idx++ and go to FETCH.
- hex(n) rules:
  - n<10: 0x30+n.
  - n≥10: 0x41+n-10 (UPPERCASE=1) or 0x61+n-10 (UPPERCASE=0).
- idx is 9 bits. It never wraps inside a dump, because the end condition idx==511 is tested before increment.
- Total text per sector: 512*3 + (512/LINE_BYTES)*2 characters. Default is 1600.

## Timing
- Reset values (asynchronous): oreq=0, odata=0x00, busy=0, done=0, overrun=0, state=IDLE, idx=0.
  - Buffer contents are not cleared.
- Reset mid-dump aborts immediately: oreq drops, and no done pulse is produced.
- Trigger write of addr 511 at cycle N:
  - busy=1 and FETCH at N+1;
  - oreq=1 with the first HI character at N+2.
- Handshake:
  - oreq is high in HI/LO/SEP/CR/LF and low in IDLE/FETCH.
  - odata is stable while oreq=1 and ogrant=0.
  - A transfer occurs on a clock edge with oreq&ogrant; the next character or FETCH follows in the next cycle.
  - ogrant while oreq=0 has no effect.
- Throughput with ogrant held high:
  - 4 cycles per byte (FETCH + 3 characters);
  - +2 cycles per line end.
  - Default parameters: last LF transfer at N+2112; done=1 and busy=0 at N+2113.
- busy falls in the same cycle done pulses. An inreq in that cycle is accepted: no overrun, and it is written.
- An inreq on the trigger cycle N itself is the trigger write. An inreq at N+1 is ignored and sets overrun.

## Test plan
- Default parameters, write buffer[i]=i for i=0..511 in order, ogrant=1 -> 1600 characters:
  - starts with "00 01 02 ... 0F \r\n";
  - ends with "FF \r\n" (byte 511 = 0xFF);
  - done at N+2113.
- Write 0xAB to all addresses with UPPERCASE=0 and LINE_BYTES=32 -> each line is "ab " x32 + 0x0D 0x0A; 16 lines; 1568 characters total.
- ogrant toggles pseudo-randomly (≈30% high) -> identical character sequence to the first test; odata never changes while oreq=1 and ogrant=0.
- During a dump, pulse inreq with addr 5 / data 0x77 -> overrun=1 and stays 1; a second dump (re-trigger with addr 511) still shows the original byte 5 value.
- Assert rst_n low after roughly 700 characters -> oreq=0, busy=0 asynchronously, no done pulse; after release, a fresh 512-byte capture produces a complete dump.
- Writes in descending address order, 511 first -> dump triggers immediately after addr 511; remaining writes are dropped and overrun=1.
